// File: rtl/disaggregator.sv
// Width-down converter: pops one FETCH_WIDTH-lane word from a wide FIFO and
// streams its lanes, lane 0 first, into a DATA_WIDTH-wide FIFO.
module disaggregator #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FETCH_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic [DATA_WIDTH-1:0]             receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq
);

    localparam int unsigned WIDE_W = FETCH_WIDTH * DATA_WIDTH;
    localparam int unsigned IDX_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FETCH_WIDTH - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDE_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid;
    logic             last;

    assign valid = (state_q == ST_DRAIN);
    assign last  = valid & (idx_q == IDX_LAST) & receiver_full_n;

    // Handshakes are forced low while rst_n is asserted; the next word is
    // pulled on the same edge that emits the final lane of the current one.
    assign receiver_enq = rst_n & valid & receiver_full_n;
    assign sender_deq   = rst_n & sender_empty_n & (~valid | last);

    // Lane select driven from registers only.
    always_comb begin
        receiver_data = '0;
        for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
            if (idx_q == IDX_W'(l)) begin
                receiver_data = hold_q[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        case (state_q)
            ST_EMPTY: begin
                if (sender_deq) begin
                    hold_d  = sender_data;
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (receiver_enq) begin
                    if (last) begin
                        idx_d = '0;
                        if (sender_deq) begin
                            hold_d = sender_data;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_disaggregator.sv
// Scoreboard bench for disaggregator: a queue-modelled wide FIFO feeds the DUT
// and a negedge monitor checks every narrow enqueue against expected lanes.
module tb_disaggregator;

    localparam int unsigned DW = 16;
    localparam int unsigned FW = 4;
    localparam int unsigned WW = DW * FW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] sender_data = '0;
    logic          sender_empty_n = 1'b0;
    logic          sender_deq;
    logic [DW-1:0] receiver_data;
    logic          receiver_full_n = 1'b0;
    logic          receiver_enq;

    always #5 clk = ~clk;

    disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sender_data     (sender_data),
        .sender_empty_n  (sender_empty_n),
        .sender_deq      (sender_deq),
        .receiver_data   (receiver_data),
        .receiver_full_n (receiver_full_n),
        .receiver_enq    (receiver_enq)
    );

    logic [WW-1:0] sq[$];
    logic [DW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_enq = 0;
    int n_deq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_word(input int unsigned v);
        logic [WW-1:0] w;
        w = '0;
        for (int l = 0; l < FW; l++) begin
            w[l*DW +: DW] = DW'(v + l);
            exp_q.push_back(DW'(v + l));
        end
        sq.push_back(w);
    endtask

    // Wide sender FIFO model: pops on the edge where sender_deq is high.
    always @(posedge clk) begin
        if (sender_deq) begin
            n_deq++;
            if (sq.size() == 0) chk("deq_on_empty", 32'd1, 32'd0);
            else void'(sq.pop_front());
        end
        #1;
        sender_empty_n = (sq.size() > 0);
        sender_data    = (sq.size() > 0) ? sq[0] : '0;
    end

    // Monitor: every enqueue must match the head of the expected queue.
    always @(negedge clk) begin
        if (receiver_enq) begin
            n_enq++;
            if (exp_q.size() == 0) chk("enq_unexpected", 32'd1, 32'd0);
            else chk("rx_data", 32'(receiver_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_enq(input int target, input string name);
        for (int i = 0; i < 50 && n_enq < target; i++) @(posedge clk);
        chk(name, 32'(n_enq >= target), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sq.size() == 0 && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
        @(negedge clk);
        chk({name, "_enq_low"}, 32'(receiver_enq), 32'd0);
    endtask

    initial begin
        int base_enq, base_deq, first, lastc, cnt, v;
        int enq_at[$];
        logic deq_at[$];

        // Reset hold with a word waiting and the receiver ready.
        receiver_full_n = 1'b1;
        push_word(0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_deq", 32'(sender_deq), 32'd0);
            chk("rst_enq", 32'(receiver_enq), 32'd0);
            chk("rst_data", 32'(receiver_data), 32'd0);
        end

        // Single word: four back-to-back enqueues after one dequeue.
        @(posedge clk); #1 rst_n = 1'b1;
        first = -1; lastc = -1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (receiver_enq) begin
                if (first < 0) first = i;
                lastc = i;
                cnt++;
            end
        end
        chk("single_enq_count", 32'(cnt), 32'd4);
        chk("single_contig", 32'(lastc - first), 32'd3);
        chk("single_deq_count", 32'(n_deq), 32'd1);
        chk("single_idle_enq", 32'(receiver_enq), 32'd0);

        // Back-to-back: three preloaded words stream as values 0..11.
        @(posedge clk); #1;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            v = 4 * k;
            push_word(v);
        end
        enq_at.delete(); deq_at.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (receiver_enq) begin
                enq_at.push_back(i);
                deq_at.push_back(sender_deq);
            end
        end
        chk("b2b_enq_count", 32'(enq_at.size()), 32'd12);
        if (enq_at.size() == 12) begin
            chk("b2b_no_bubble", 32'(enq_at[11] - enq_at[0]), 32'd11);
            chk("b2b_deq_lane3", 32'(deq_at[3]), 32'd1);
            chk("b2b_deq_lane7", 32'(deq_at[7]), 32'd1);
            chk("b2b_nodeq_lane11", 32'(deq_at[11]), 32'd0);
            chk("b2b_nodeq_lane2", 32'(deq_at[2]), 32'd0);
        end
        wait_idle("b2b_idle");

        // Receiver stall while lane 2 is offered.
        base_enq = n_enq;
        @(posedge clk); #1;
        push_word(100);
        push_word(104);
        wait_enq(base_enq + 2, "stall_reach_lane2");
        #1 receiver_full_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", 32'(receiver_data), 32'h66);
            chk("stall_enq", 32'(receiver_enq), 32'd0);
            chk("stall_deq", 32'(sender_deq), 32'd0);
        end
        @(posedge clk); #1 receiver_full_n = 1'b1;
        @(negedge clk);
        chk("stall_release_data", 32'(receiver_data), 32'h66);
        chk("stall_release_enq", 32'(receiver_enq), 32'd1);
        wait_idle("stall_idle");

        // Random stress with an incrementing source.
        base_enq = n_enq;
        base_deq = n_deq;
        v = 1000;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            receiver_full_n = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && sq.size() < 3) begin
                push_word(v);
                v += 4;
            end
        end
        @(posedge clk); #1 receiver_full_n = 1'b1;
        wait_idle("stress_idle");
        chk("stress_enq_vs_deq", 32'(n_enq - base_enq), 32'(4 * (n_deq - base_deq)));
        chk("stress_total", 32'(n_enq - base_enq), 32'(v - 1000));

        // Reset after lane 1: lanes 2 and 3 are discarded.
        base_enq = n_enq;
        @(posedge clk); #1;
        push_word(200);
        wait_enq(base_enq + 2, "rstmid_reach_lane1");
        #1 rst_n = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_enq", 32'(receiver_enq), 32'd0);
            chk("rstmid_deq", 32'(sender_deq), 32'd0);
        end
        chk("rstmid_data", 32'(receiver_data), 32'd0);
        chk("rstmid_enq_total", 32'(n_enq - base_enq), 32'd2);
        @(posedge clk); #1 rst_n = 1'b1;
        push_word(300);
        wait_idle("rstmid_idle");

        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
